// File: rtl/md_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : md_mem_pkg                                                    |
// | Description: Shared types and constants for the velocity cell RAM          |
// |              sequencer (state encoding, velocity word, fixed addresses).   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package md_mem_pkg;

  // Velocity word is {vz, vy, vx}, three 32-bit floats
  localparam int VEL_WIDTH = 96;

  // Address 0 holds the particle count; particles live at 1..N
  localparam int CNT_ADDR        = 0;
  localparam int FIRST_PART_ADDR = 1;

  typedef logic [VEL_WIDTH-1:0] vel_word_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CNT_RD   = 3'd1,
    ST_CNT_WAIT = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_FIN      = 3'd5
  } vc_state_t;

  // Limit a raw count read from RAM to what the cell can actually hold
  function automatic int unsigned clamp_count(input int unsigned raw,
                                              input int unsigned max_cnt);
    return (raw > max_cnt) ? max_cnt : raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/velocity_cell_ctrl_rd_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : rd_tag_pipe                                                   |
// | Description: DEPTH-stage {valid, addr} shift register that travels         |
// |              alongside the RAM read latency so returning data can be       |
// |              tagged with the particle address it belongs to.               |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rd_tag_pipe #(
  parameter int DEPTH      = 1,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  pending
);

  logic [DEPTH-1:0]      r_valid;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];

  // Shift tags one stage per cycle; an idle slot carries address 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      r_addr[0]  <= in_valid ? in_addr : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_addr  = r_addr[DEPTH-1];
  // Any read still on its way back from the RAM
  assign pending   = |r_valid;

endmodule
`default_nettype wire

// File: rtl/velocity_cell_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : velocity_cell_ctrl                                            |
// | Description: Sequences a single-port velocity cell RAM for one motion-     |
// |              update pass: reads the particle count at address 0, streams   |
// |              velocities 1..N out, and shares the port with write-backs     |
// |              (write-backs win).                                            |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module velocity_cell_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LAT       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] cell_cnt,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rden,
  output logic                  ram_wren,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ready
);

  import md_mem_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] c_max_cnt   = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [1:0]            c_wait_last = 2'(RD_LAT - 1);

  vc_state_t             r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_cell_cnt;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_wb_count;   // one bit wider so a full cell cannot wrap
  logic [1:0]            r_wait_cnt;

  logic                  w_arb_win;
  logic                  w_wb_fire;
  logic                  w_rd_issue;
  logic                  w_cnt_rd;
  logic [ADDR_WIDTH:0]   w_wb_count_nxt;
  logic [ADDR_WIDTH-1:0] w_cnt_clamped;
  logic                  w_tag_valid;
  logic [ADDR_WIDTH-1:0] w_tag_addr;
  logic                  w_tag_pending;

  // Port is shared only while streaming/draining; a write-back always wins the cycle
  assign w_arb_win      = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
  assign w_wb_fire      = wb_valid && w_arb_win;
  assign w_rd_issue     = (r_state == ST_STREAM) && !wb_valid;
  assign w_cnt_rd       = (r_state == ST_CNT_RD);
  assign w_wb_count_nxt = r_wb_count + (ADDR_WIDTH + 1)'(w_wb_fire);
  assign w_cnt_clamped  = ADDR_WIDTH'(clamp_count(32'(ram_q[ADDR_WIDTH-1:0]),
                                                  32'(c_max_cnt)));

  // Drive the single RAM port: write-back, else stream read, else count read
  always_comb begin
    ram_addr  = '0;
    ram_rden  = 1'b0;
    ram_wren  = 1'b0;
    ram_wdata = '0;
    if (w_wb_fire) begin
      ram_wren  = 1'b1;
      ram_addr  = wb_addr;
      ram_wdata = wb_data;
    end else if (w_rd_issue) begin
      ram_rden  = 1'b1;
      ram_addr  = r_rd_ptr;
    end else if (w_cnt_rd) begin
      ram_rden  = 1'b1;
      ram_addr  = ADDR_WIDTH'(CNT_ADDR);
    end
  end

  // Pass sequencer with registered busy/done/cell_cnt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cell_cnt <= '0;
      r_rd_ptr   <= '0;
      r_wb_count <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_CNT_RD;
            r_busy     <= 1'b1;
            r_rd_ptr   <= ADDR_WIDTH'(FIRST_PART_ADDR);
            r_wb_count <= '0;
          end
        end
        ST_CNT_RD: begin
          r_state    <= ST_CNT_WAIT;
          r_wait_cnt <= '0;
        end
        ST_CNT_WAIT: begin
          if (r_wait_cnt == c_wait_last) begin
            r_cell_cnt <= w_cnt_clamped;
            if (w_cnt_clamped == '0) begin
              r_state <= ST_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_STREAM;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end
        ST_STREAM: begin
          r_wb_count <= w_wb_count_nxt;
          if (w_rd_issue) begin
            if (r_rd_ptr == r_cell_cnt) begin
              r_state <= ST_DRAIN;
            end else begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          r_wb_count <= w_wb_count_nxt;
          // Finish once every read has returned and this cycle's write-back completes the set
          if (!w_tag_pending && (w_wb_count_nxt == {1'b0, r_cell_cnt})) begin
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  rd_tag_pipe #(
    .DEPTH      (RD_LAT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_rd_issue),
    .in_addr   (r_rd_ptr),
    .out_valid (w_tag_valid),
    .out_addr  (w_tag_addr),
    .pending   (w_tag_pending)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign cell_cnt = r_cell_cnt;
  assign wb_ready = w_wb_fire;
  assign rd_valid = w_tag_valid;
  assign rd_addr  = w_tag_addr;
  // RAM data passes straight through; masked so stale q never leaks out
  assign rd_data  = w_tag_valid ? ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_velocity_cell_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_velocity_cell_ctrl                                         |
// | Description: Self-checking bench for velocity_cell_ctrl: behavioural RAM,  |
// |              per-cycle reference model and directed pass scenarios.        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_velocity_cell_ctrl;

  localparam int DW     = 96;
  localparam int AW     = 8;
  localparam int PNUM   = 220;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] cell_cnt, ram_addr;
  logic          ram_rden, ram_wren;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_q = '0;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_ready;

  velocity_cell_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PNUM), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .cell_cnt(cell_cnt), .ram_addr(ram_addr), .ram_rden(ram_rden),
    .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_q(ram_q),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int i);
    return {32'(i * 7 + 1), 32'(i) ^ 32'hC0DE_0000, 32'(i) << 8};
  endfunction

  // ---------------- behavioural RAM (1-cycle latency) -------------------------
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] cnt_word = '0;   // contents of address 0, set per scenario

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_rden) ram_q <= (ram_addr == 0) ? cnt_word : mem[ram_addr];
  end

  // ---------------- bookkeeping -----------------------------------------------
  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model -------------------------------------------
  typedef struct { int cyc; int addr; logic [DW-1:0] data; } ret_t;

  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_since = 0, m_cnt = 0, m_next = 1, m_wb = 0;
  logic [7:0]  m_cell = '0;
  ret_t        m_q[$];

  int rd_log_addr[$];
  int rd_log_cyc[$];
  int n_addr0 = 0, n_done = 0, last_done = -1;

  always @(negedge clk) begin : model
    logic e_cntrd, e_win, e_wbr, e_rd, e_rv, fin, accept;
    int   outst;
    ret_t ent;
    // Expected behaviour of this cycle derived from the pass timeline
    e_cntrd = m_busy && (m_since == 1);
    e_win   = m_busy && (m_since >= RD_LAT + 2) && (m_cnt != 0);
    e_wbr   = wb_valid && e_win;
    e_rd    = e_win && !wb_valid && (m_next <= m_cnt);
    e_rv    = (m_q.size() > 0) && (m_q[0].cyc == cyc);

    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("cell_cnt", cell_cnt, m_cell);
    chk("wb_ready", wb_ready, e_wbr);
    chk("ram_wren", ram_wren, e_wbr);
    chk("ram_rden", ram_rden, e_rd || e_cntrd);
    if (e_wbr) begin
      chk("wr_addr", ram_addr, wb_addr);
      chk("wr_data", ram_wdata, wb_data);
    end else if (e_rd) begin
      chk("rd_issue_addr", ram_addr, m_next);
    end else if (e_cntrd) begin
      chk("cnt_rd_addr", ram_addr, 0);
    end
    chk("rd_valid", rd_valid, e_rv);
    if (e_rv) begin
      chk("rd_addr", rd_addr, m_q[0].addr);
      chk("rd_data", rd_data, m_q[0].data);
    end

    if (rd_valid) begin
      rd_log_addr.push_back(int'(rd_addr));
      rd_log_cyc.push_back(cyc);
    end
    if (ram_rden && ram_addr == 0) n_addr0++;
    if (done) begin
      n_done++;
      last_done = cyc;
    end

    // Advance the model across the coming clock edge
    outst  = m_q.size();
    accept = !m_busy && !m_done && start;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_since = 0; m_cnt = 0;
      m_next = 1; m_wb = 0; m_cell = '0;
      m_q.delete();
    end else begin
      fin = 1'b0;
      if (e_rv) void'(m_q.pop_front());
      if (e_win && m_next > m_cnt && outst == 0 && (m_wb + (e_wbr ? 1 : 0)) == m_cnt)
        fin = 1'b1;
      if (e_rd) begin
        ent.cyc  = cyc + RD_LAT;
        ent.addr = m_next;
        ent.data = mem[m_next];
        m_q.push_back(ent);
        m_next++;
      end
      if (e_wbr) m_wb++;
      if (m_busy && m_since == RD_LAT + 1) begin
        m_cnt  = (cnt_word[7:0] > 8'(PNUM - 1)) ? PNUM - 1 : int'(cnt_word[7:0]);
        m_cell = 8'(m_cnt);
        if (m_cnt == 0) fin = 1'b1;
      end
      if (fin) m_busy = 1'b0;
      else if (m_busy) m_since++;
      if (accept) begin
        m_busy = 1'b1; m_since = 1; m_next = 1; m_wb = 0;
      end
      m_done = fin;
    end
    cyc++;
  end

  // ---------------- stimulus helpers ------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    rd_log_addr.delete(); rd_log_cyc.delete();
    n_addr0 = 0; n_done = 0; last_done = -1;
  endtask

  task automatic pulse_start(output int s);
    s = cyc; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_rd(input int n, input int budget);
    int k = 0;
    while (rd_log_addr.size() < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    chk("rd_count", rd_log_addr.size(), n);
    tick();
  endtask

  task automatic wait_done(input int budget);
    int tgt = n_done + 1;
    int k = 0;
    while (n_done < tgt && k < budget) begin
      @(negedge clk); #1; k++;
    end
    chk("done_seen", n_done, tgt);
    tick();
  endtask

  task automatic do_wb(input int a, output int acc);
    int   k = 0;
    logic got = 1'b0;
    wb_valid = 1'b1; wb_addr = 8'(a); wb_data = ~pat(a);
    acc = -1;
    while (!got && k < 40) begin
      @(negedge clk); #1;
      got = wb_ready; k++;
      if (got) acc = cyc - 1;
      @(posedge clk); #1;
    end
    chk("wb_accepted", got, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------------------------------
  initial begin : stim
    int s, w, fw;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Empty cell
    cnt_word = '0; clear_logs();
    pulse_start(s);
    wait_done(20);
    chk("empty_done_cycle", last_done, s + RD_LAT + 2);
    chk("empty_addr0_reads", n_addr0, 1);
    chk("empty_no_rd_valid", rd_log_addr.size(), 0);
    chk("empty_cell_cnt", cell_cnt, 0);

    // Four particles, write-backs only after all reads
    cnt_word = 96'd4; clear_logs();
    pulse_start(s);
    wait_rd(4, 40);
    chk("cnt4_cell_cnt", cell_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk("cnt4_rd_addr", rd_log_addr[i], i + 1);
      chk("cnt4_rd_cycle", rd_log_cyc[i], s + 2 * RD_LAT + 2 + i);
    end
    for (int a = 1; a <= 4; a++) do_wb(a, w);
    wb_valid = 1'b0;
    wait_done(20);
    chk("cnt4_done_after_wb", last_done, w + 1);

    // Three particles, write-backs hogging the port from stream entry
    cnt_word = 96'd3; clear_logs();
    s = cyc; start = 1'b1; tick(); start = 1'b0;
    do_wb(1, fw);
    do_wb(2, w);
    do_wb(3, w);
    wb_valid = 1'b0;
    chk("cnt3_first_wb_cycle", fw, s + RD_LAT + 2);
    wait_rd(3, 40);
    for (int i = 0; i < 3; i++) chk("cnt3_rd_addr", rd_log_addr[i], i + 1);
    chk("cnt3_first_rd_cycle", rd_log_cyc[0], fw + 3 + RD_LAT);
    wait_done(20);
    chk("cnt3_done_cycle", last_done, rd_log_cyc[2] + 2);

    // Count clamp: low byte 0xFF must saturate at PARTICLE_NUM-1
    cnt_word = {32'h0, 32'h1, 32'h0000_01FF}; clear_logs();
    pulse_start(s);
    wait_rd(219, 400);
    chk("clamp_cell_cnt", cell_cnt, 219);
    chk("clamp_last_rd_addr", rd_log_addr[rd_log_addr.size() - 1], 219);
    for (int a = 1; a <= 219; a++) do_wb(a, w);
    wb_valid = 1'b0;
    wait_done(20);
    chk("clamp_done_cycle", last_done, w + 1);

    // start while busy and in the done cycle must be ignored
    cnt_word = 96'd2; clear_logs();
    pulse_start(s);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_rd(2, 40);
    do_wb(1, w);
    do_wb(2, w);
    wb_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    chk("ign_done_count", n_done, 1);
    chk("ign_done_cycle", last_done, w + 1);
    chk("ign_addr0_reads", n_addr0, 1);
    chk("ign_rd_count", rd_log_addr.size(), 2);
    chk("ign_busy_idle", busy, 1'b0);

    // Reset in the middle of streaming five particles
    cnt_word = 96'd5; clear_logs();
    pulse_start(s);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    wb_valid = 1'b1; wb_addr = 8'd3; wb_data = ~pat(3);
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cell_cnt", cell_cnt, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_rden", ram_rden, 0);
    chk("rst_ram_wren", ram_wren, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wb_ready", wb_ready, 0);
    tick();
    rst_n = 1'b1; wb_valid = 1'b0;
    repeat (4) tick();
    chk("rst_rd_before_abort", rd_log_addr.size(), 1);
    chk("rst_no_done", n_done, 0);
    clear_logs();
    pulse_start(s);
    wait_rd(5, 40);
    chk("rst_reread_addr0", n_addr0, 1);
    for (int a = 1; a <= 5; a++) do_wb(a, w);
    wb_valid = 1'b0;
    wait_done(20);
    chk("rst_pass_done_cycle", last_done, w + 1);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
